muldiv_sequencer: RTL and testbench



---
 rtl/muldiv_sequencer_if.sv | 23 ++
 rtl/muldiv_sequencer.sv | 145 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer bus: op issue, flush, status and HI/LO.
interface muldiv_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: radix-2 shift-add multiply,
// restoring divide, one iteration per cycle over 32 cycles, signs applied in FIXUP.
module muldiv_sequencer (
  input  logic clk,
  input  logic rst_n,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIXUP = 2'd2} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  logic        r_done, r_dbz;
  logic [31:0] r_hi, r_lo;
  logic        r_div, r_zero, r_neg_q, r_neg_r;
  logic [31:0] r_b, r_acc_hi, r_acc_lo;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  logic signed [31:0] w_rs_s, w_rt_s;
  logic        w_idle_go, w_start_md, w_start_mt;
  logic        w_op_div, w_op_signed, w_rs_neg, w_rt_neg, w_rt_zero;
  logic [31:0] w_rs_mag, w_rt_mag;

  assign w_rs_s      = bus.rs_data;
  assign w_rt_s      = bus.rt_data;
  assign w_idle_go   = (r_state == IDLE) && bus.start && !bus.flush;
  assign w_start_md  = w_idle_go && !bus.op[2];
  assign w_start_mt  = w_idle_go && ((bus.op == OP_MTHI) || (bus.op == OP_MTLO));
  assign w_op_div    = bus.op[1];
  assign w_op_signed = !bus.op[0];
  assign w_rs_neg    = w_op_signed && (w_rs_s < 0);
  assign w_rt_neg    = w_op_signed && (w_rt_s < 0);
  assign w_rt_zero   = (bus.rt_data == 32'd0);
  // -2^31 maps to 0x8000_0000, which is exactly its unsigned magnitude.
  assign w_rs_mag    = cneg32(bus.rs_data, w_rs_neg);
  assign w_rt_mag    = cneg32(bus.rt_data, w_rt_neg);

  logic [32:0] w_sum, w_shift;
  logic [31:0] w_diff, w_iter_hi, w_iter_lo;
  logic        w_ge;

  // {r_acc_hi, r_acc_lo} is the product accumulator or {remainder, quotient}.
  always_comb begin
    w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : 33'd0);
    w_shift = {r_acc_hi, r_acc_lo[31]};
    w_ge    = (w_shift >= {1'b0, r_b});
    w_diff  = w_shift[31:0] - r_b;
    if (r_div) begin
      w_iter_hi = w_ge ? w_diff : w_shift[31:0];
      w_iter_lo = {r_acc_lo[30:0], w_ge};
    end else begin
      w_iter_hi = w_sum[32:1];
      w_iter_lo = {w_sum[0], r_acc_lo[31:1]};
    end
  end

  logic [63:0] w_prod;
  logic [31:0] w_res_hi, w_res_lo;

  always_comb begin
    w_prod = cneg64({r_acc_hi, r_acc_lo}, r_neg_q);
    if (r_zero) begin
      w_res_hi = r_acc_hi;
      w_res_lo = 32'hFFFF_FFFF;
    end else if (r_div) begin
      w_res_hi = cneg32(r_acc_hi, r_neg_r);
      w_res_lo = cneg32(r_acc_lo, r_neg_q);
    end else begin
      w_res_hi = w_prod[63:32];
      w_res_lo = w_prod[31:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_md) w_state_nxt = (w_op_div && w_rt_zero) ? FIXUP : RUN;
      RUN:     if (bus.flush) w_state_nxt = IDLE;
               else if (r_cnt == 5'd31) w_state_nxt = FIXUP;
      FIXUP:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_start_md) begin
        r_cnt <= 5'd0;
        r_dbz <= 1'b0;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_start_mt) begin
        if (bus.op[0]) r_lo <= bus.rs_data;
        else           r_hi <= bus.rs_data;
      end
      // A flush in the FIXUP cycle discards the result entirely.
      if ((r_state == FIXUP) && !bus.flush) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
        if (r_zero) r_dbz <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_start_md) begin
      r_div    <= w_op_div;
      r_zero   <= w_op_div && w_rt_zero;
      r_neg_q  <= w_rs_neg ^ w_rt_neg;
      r_neg_r  <= w_rs_neg;
      r_acc_hi <= (w_op_div && w_rt_zero) ? bus.rs_data : 32'd0;
      r_acc_lo <= w_op_div ? w_rs_mag : w_rt_mag;
      r_b      <= w_op_div ? w_rt_mag : w_rs_mag;
    end else if (r_state == RUN) begin
      r_acc_hi <= w_iter_hi;
      r_acc_lo <= w_iter_lo;
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, timing, flush, reset.
module tb_muldiv_sequencer;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Issue one op at edge E0 and watch samples taken 1ns after E0..E35.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_k, input int flush_k,
                        output int nbusy, output int ndone, output int didx, output bit leak);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = bus.hi; l0 = bus.lo;
    bus.start = 1'b1; bus.op = o; bus.rs_data = a; bus.rt_data = b;
    nbusy = 0; ndone = 0; didx = -1; leak = 1'b0;
    for (int k = 0; k < 36; k++) begin
      @(posedge clk); #1;
      if (bus.busy) begin
        nbusy++;
        if (bus.hi !== h0 || bus.lo !== l0) leak = 1'b1;
      end
      if (bus.done) begin
        ndone++;
        if (didx < 0) didx = k;
      end
      bus.flush = (k + 1 == flush_k);
      if (k + 1 == poke_k) begin
        bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_data = 32'h5555_5555;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'b000;
    bus.rs_data = 32'd0; bus.rt_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu_max();
    int nb, nd, di; bit lk;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, nb, nd, di, lk);
    n_checks++; if (bus.hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_max_hi: got %h expected fffffffe", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_max_lo: got %h expected 00000001", bus.lo); end
    n_checks++; if (nb !== 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 33", nb); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL multu_done_count: got %0d expected 1", nd); end
    n_checks++; if (di !== 33) begin n_fail++; $display("FAIL multu_done_cycle: got %0d expected 33", di); end
    n_checks++; if (lk !== 1'b0) begin n_fail++; $display("FAIL multu_hilo_leak: got %b expected 0", lk); end
  endtask

  task automatic test_signed();
    int nb, nd, di; bit lk;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, -1, nb, nd, di, lk);
    n_checks++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h expected ffffffff", bus.hi); end
    n_checks++; if (bus.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", bus.lo); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1, nb, nd, di, lk);
    n_checks++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", bus.lo); end
    n_checks++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", bus.hi); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL div_done_count: got %0d expected 1", nd); end
  endtask

  task automatic test_div_overflow();
    int nb, nd, di; bit lk;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, nb, nd, di, lk);
    n_checks++; if (bus.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.lo); end
    n_checks++; if (bus.hi !== 32'h0000_0000) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 00000000", bus.hi); end
    run_op(OP_DIVU, 32'd100, 32'd7, -1, -1, nb, nd, di, lk);
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h expected 0000000e", bus.lo); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h expected 00000002", bus.hi); end
    n_checks++; if (nb !== 33) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d expected 33", nb); end
  endtask

  task automatic test_div_by_zero();
    int nb, nd, di; bit lk;
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, -1, -1, nb, nd, di, lk);
    n_checks++; if (nb !== 1) begin n_fail++; $display("FAIL dbz_busy_cycles: got %0d expected 1", nb); end
    n_checks++; if (di !== 1) begin n_fail++; $display("FAIL dbz_done_cycle: got %0d expected 1", di); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL dbz_done_count: got %0d expected 1", nd); end
    n_checks++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_lo: got %h expected ffffffff", bus.lo); end
    n_checks++; if (bus.hi !== 32'h0000_1234) begin n_fail++; $display("FAIL dbz_hi: got %h expected 00001234", bus.hi); end
    n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag_set: got %b expected 1", bus.div_by_zero); end
    run_op(OP_MULTU, 32'd5, 32'd6, -1, -1, nb, nd, di, lk);
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_flag_clear: got %b expected 0", bus.div_by_zero); end
    n_checks++; if (bus.lo !== 32'd30) begin n_fail++; $display("FAIL multu_5x6_lo: got %h expected 0000001e", bus.lo); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    n_checks++; if (bus.hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mthi_hi: got %h expected deadbeef", bus.hi); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", bus.busy); end
    bus.op = OP_MTLO; bus.rs_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++; if (bus.lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 0badf00d", bus.lo); end
    n_checks++; if (bus.hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mtlo_hi_hold: got %h expected deadbeef", bus.hi); end
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy_done: got %b%b expected 00", bus.busy, bus.done); end
  endtask

  task automatic test_flush();
    int nb, nd, di; bit lk;
    run_op(OP_MULTU, 32'd5, 32'd6, -1, 15, nb, nd, di, lk);
    n_checks++; if (nb !== 15) begin n_fail++; $display("FAIL flush_busy_cycles: got %0d expected 15", nb); end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL flush_done_count: got %0d expected 0", nd); end
    n_checks++; if (bus.hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL flush_hi_hold: got %h expected deadbeef", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL flush_lo_hold: got %h expected 0badf00d", bus.lo); end
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MTHI; bus.rs_data = 32'h1111_1111;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL flush_idle_mthi: got %h expected deadbeef", bus.hi); end
  endtask

  task automatic test_unused_op();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.op = (i == 0) ? 3'b110 : 3'b111;
      bus.rs_data = 32'h2222_2222; bus.rt_data = 32'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL unused_op_busy: got %b expected 0 (op %0d)", bus.busy, i + 6); end
      n_checks++; if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL unused_op_hilo: got %h/%h expected deadbeef/0badf00d", bus.hi, bus.lo); end
    end
  endtask

  task automatic test_start_while_busy();
    int nb, nd, di; bit lk;
    run_op(OP_MULTU, 32'd3, 32'd4, 10, -1, nb, nd, di, lk);
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL busy_start_hi: got %h expected 00000000", bus.hi); end
    n_checks++; if (bus.lo !== 32'd12) begin n_fail++; $display("FAIL busy_start_lo: got %h expected 0000000c", bus.lo); end
    n_checks++; if (nb !== 33 || nd !== 1) begin n_fail++; $display("FAIL busy_start_timing: got busy %0d done %0d expected 33 1", nb, nd); end
    n_checks++; if (lk !== 1'b0) begin n_fail++; $display("FAIL busy_start_leak: got %b expected 0", lk); end
  endtask

  task automatic test_back_to_back();
    bit got;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (bus.done) got = 1'b1;
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1 within 40 cycles", got); end
    n_checks++; if (bus.busy !== 1'b0 || bus.lo !== 32'd6) begin n_fail++; $display("FAIL b2b_first_result: got busy %b lo %h expected 0 00000006", bus.busy, bus.lo); end
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b expected 1", bus.busy); end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (bus.done) got = 1'b1;
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done: got %b expected 1 within 40 cycles", got); end
    n_checks++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin n_fail++; $display("FAIL b2b_second_result: got %h/%h expected 00000002/0000000e", bus.hi, bus.lo); end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'd5; bus.rt_data = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_fail++; $display("FAIL midrun_reset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
    n_checks++; if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_flags: got %b%b expected 00", bus.done, bus.div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_overflow();
    test_div_by_zero();
    test_mthi_mtlo();
    test_flush();
    test_unused_op();
    test_start_while_busy();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
